// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sequencer
// Description : EX-stage multiply/divide unit (shift-add / restoring divide)
//               owning the HI/LO pair and stalling colliding MD instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        OpCode,
    input  logic [5:0]        Funct,
    input  logic              flush,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] mf_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                div0_q, div0_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic is_rtype, f_mult, f_multu, f_div, f_divu, f_mthi, f_mtlo, f_mfhi, f_mflo;
    logic is_md, md_op, accept, signed_op, rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    always_comb begin
        is_rtype  = (OpCode == 6'h00);
        f_mult    = is_rtype && (Funct == F_MULT);
        f_multu   = is_rtype && (Funct == F_MULTU);
        f_div     = is_rtype && (Funct == F_DIV);
        f_divu    = is_rtype && (Funct == F_DIVU);
        f_mthi    = is_rtype && (Funct == F_MTHI);
        f_mtlo    = is_rtype && (Funct == F_MTLO);
        f_mfhi    = is_rtype && (Funct == F_MFHI);
        f_mflo    = is_rtype && (Funct == F_MFLO);
        is_md     = f_mult | f_multu | f_div | f_divu | f_mthi | f_mtlo | f_mfhi | f_mflo;
        md_op     = start & is_md & ~flush;
        accept    = md_op & ~busy;
        signed_op = f_mult | f_div;
        rs_neg    = signed_op & rs_data[DATA_W-1];
        rt_neg    = signed_op & rt_data[DATA_W-1];
        rs_mag    = rs_neg ? -rs_data : rs_data;
        rt_mag    = rt_neg ? -rt_data : rt_data;
    end

    assign busy  = (state_q != ST_IDLE);
    assign stall = md_op & busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        mf_data = '0;
        if (Funct == F_MFHI) begin
            mf_data = hi_q;
        end else if (Funct == F_MFLO) begin
            mf_data = lo_q;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath: acc holds {HI-half, LO-half} of the work register
    // ------------------------------------------------------------------
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W-1:0]   div_sub;
    logic                div_ge;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] mul_res;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // When div_ge holds the difference is below the divisor, so W bits suffice
        div_sub   = div_shift[DATA_W-1:0] - opnd_q;
        div_next  = {(div_ge ? div_sub : div_shift[DATA_W-1:0]), acc_q[DATA_W-2:0], div_ge};
        mul_res   = neg_lo_q ? -acc_q : acc_q;
        quo_fix   = div0_q ? '1 : (neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
        rem_fix   = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (f_mthi) hi_d = rs_data;
                        if (f_mtlo) lo_d = rs_data;
                        if (f_mult | f_multu) begin
                            state_d  = ST_MUL;
                            cnt_d    = '0;
                            acc_d    = {{DATA_W{1'b0}}, rt_mag};
                            opnd_d   = rs_mag;
                            is_div_d = 1'b0;
                            neg_lo_d = rs_neg ^ rt_neg;
                            neg_hi_d = 1'b0;
                            div0_d   = 1'b0;
                        end
                        if (f_div | f_divu) begin
                            state_d  = ST_DIV;
                            cnt_d    = '0;
                            acc_d    = {{DATA_W{1'b0}}, rs_mag};
                            opnd_d   = rt_mag;
                            is_div_d = 1'b1;
                            neg_lo_d = rs_neg ^ rt_neg;
                            neg_hi_d = rs_neg;
                            div0_d   = (rt_data == '0);
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_d = (state_q == ST_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                        cnt_d   = '0;
                    end
                end
                ST_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = mul_res[2*DATA_W-1:DATA_W];
                        lo_d = mul_res[DATA_W-1:0];
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sequencer
// Description : Scoreboard bench for mdu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    mdu_sequencer #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .OpCode  (OpCode),
        .Funct   (Funct),
        .flush   (flush),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .stall   (stall),
        .busy    (busy),
        .mf_data (mf_data),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo}
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] ua, ub;
        sa = int'(a);
        sb = int'(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        model = '0;
        case (f)
            6'h18: begin
                p = longint'(sa) * longint'(sb);
                model = 64'(p);
            end
            6'h19: model = ua * ub;
            6'h1A: begin
                if (b == 32'h0)                                 model = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = {32'h0, 32'h80000000};
                else                                            model = {32'(sa % sb), 32'(sa / sb)};
            end
            6'h1B: begin
                if (b == 32'h0) model = {a, 32'hFFFFFFFF};
                else            model = {a % b, a / b};
            end
            default: model = '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
        OpCode  = 6'h00;
        Funct   = f;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        if (push) exp_q.push_back(model(f, a, b));
    endtask

    task automatic finish_md(input string tag, input int elapsed);
        int          cyc;
        logic [63:0] e;
        cyc = elapsed;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd33);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, {32'h0, hi}, {32'h0, e[63:32]});
            check({tag, "_lo"}, {32'h0, lo}, {32'h0, e[31:0]});
        end
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        accept_md(f, a, b, 1'b1);
        finish_md(tag, 0);
    endtask

    task automatic do_mt(input logic [5:0] f, input logic [31:0] a);
        OpCode  = 6'h00;
        Funct   = f;
        rs_data = a;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        logic [31:0] hb;
        logic [63:0] e;
        int          cyc;
        logic [5:0]  kinds [4];
        kinds[0] = 6'h18; kinds[1] = 6'h19; kinds[2] = 6'h1A; kinds[3] = 6'h1B;

        reset = 1'b1; start = 1'b0; OpCode = 6'h00; Funct = 6'h10;
        flush = 1'b0; rs_data = '0; rt_data = '0;
        #2 reset = 1'b0;
        #10;
        check("rst_busy",  {63'h0, busy},  64'd0);
        check("rst_stall", {63'h0, stall}, 64'd0);
        check("rst_hi",    {32'h0, hi},    64'd0);
        check("rst_lo",    {32'h0, lo},    64'd0);
        check("rst_mf",    {32'h0, mf_data}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        run_md("mult",  6'h18, 32'hFFFFFFFE, 32'd3);
        run_md("multu", 6'h19, 32'hFFFFFFFE, 32'd3);
        run_md("div",   6'h1A, 32'hFFFFFFF9, 32'd2);
        run_md("divu0", 6'h1B, 32'd7, 32'd0);
        run_md("divov", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        run_md("div0s", 6'h1A, 32'hFFFFFFF9, 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            run_md("rand", kinds[$urandom_range(0, 3)], a, b);
        end

        // mflo waits behind a multiply, then reads the fresh LO
        accept_md(6'h18, 32'h00012345, 32'hFFFF0003, 1'b1);
        repeat (4) tick();
        Funct = 6'h12;
        start = 1'b1;
        cyc   = 4;
        while (busy && cyc < 40) begin
            #1;
            check("mflo_stall", {63'h0, stall}, 64'd1);
            tick();
            cyc++;
        end
        check("mflo_lat", 64'(cyc), 64'd33);
        check("mflo_nostall", {63'h0, stall}, 64'd0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mflo_data", {32'h0, mf_data}, {32'h0, e[31:0]});
            check("mflo_hi",   {32'h0, hi},      {32'h0, e[63:32]});
        end else begin
            check("mflo_sb_empty", 64'd0, 64'd1);
        end
        tick();
        start = 1'b0;

        // mthi while idle
        do_mt(6'h11, 32'h12345678);
        check("mthi_hi",   {32'h0, hi}, 64'h12345678);
        check("mthi_busy", {63'h0, busy}, 64'd0);

        // mthi while busy is refused; non-MD opcode never stalls
        accept_md(6'h19, 32'd1000, 32'd77, 1'b1);
        hb      = hi;
        Funct   = 6'h11;
        rs_data = 32'hDEADBEEF;
        start   = 1'b1;
        #1;
        check("mthi_busy_stall", {63'h0, stall}, 64'd1);
        OpCode = 6'h04;
        #1;
        check("nonmd_stall", {63'h0, stall}, 64'd0);
        OpCode = 6'h00;
        tick();
        check("mthi_busy_hi", {32'h0, hi}, {32'h0, hb});
        start = 1'b0;
        finish_md("mthi_bg", 1);

        // flush mid-divide keeps HI/LO
        do_mt(6'h11, 32'h0000AAAA);
        do_mt(6'h13, 32'h00005555);
        accept_md(6'h1A, 32'd1000, 32'd7, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {63'h0, busy}, 64'd0);
        check("flush_hi",   {32'h0, hi},   64'h0000AAAA);
        check("flush_lo",   {32'h0, lo},   64'h00005555);
        repeat (3) tick();
        check("flush_hold_lo", {32'h0, lo}, 64'h00005555);

        // flush and start together: nothing accepted
        OpCode = 6'h00; Funct = 6'h11; rs_data = 32'h11111111;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_hi",   {32'h0, hi},   64'h0000AAAA);
        check("flush_start_busy", {63'h0, busy}, 64'd0);

        // asynchronous reset mid-multiply
        accept_md(6'h18, 32'd5, 32'd9, 1'b0);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("arst_hi",   {32'h0, hi},   64'd0);
        check("arst_lo",   {32'h0, lo},   64'd0);
        check("arst_busy", {63'h0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_md("post_rst", 6'h18, 32'hFFFFFFF0, 32'hFFFFFFF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide unit and controller for the pipeline's HI/LO register pair, sitting in the EX stage alongside the ALU.
- Decodes R-type mult/multu/div/divu/mfhi/mthi/mflo/mtlo.
- Sequences a 32-iteration shift-add multiplier or restoring divider.
- Owns HI/LO.
- Raises a stall to the hazard logic while a HI/LO access collides with an operation in flight.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W; counter width is clog2(DATA_W).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  EX-stage instruction valid this cycle
OpCode  in  6  instruction opcode
Funct  in  6  instruction funct field
flush  in  1  squash EX-stage instruction and abort any operation in flight
rs_data  in  DATA_W  forwarded rs operand
rt_data  in  DATA_W  forwarded rt operand
stall  out  1  hold IF/ID/EX this cycle
busy  out  1  sequencer not IDLE
mf_data  out  DATA_W  HI (mfhi) or LO (mflo) read data, combinational
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register

Behaviour:
- Decode applies only when OpCode==6'h00.
  - Funct 18=mult, 19=multu, 1A=div, 1B=divu, 10=mfhi, 11=mthi, 12=mflo, 13=mtlo (hex).
  - md_op = start & one of these eight & !flush.
- Reset (reset==0, async):
  - state=IDLE; counter=0; hi=0; lo=0; busy=0; stall=0; mf_data=0.
  - Internal accumulator/operand registers are cleared.
- stall = md_op & busy (combinational). Any MD instruction, including mfhi/mflo/mthi/mtlo, is refused while busy. The pipeline holds it and it is re-presented each cycle.
- Accepted op = md_op & !busy.
- mf_data: hi when Funct==10, lo when Funct==12, else 0; combinational.
- mthi: hi<=rs_data at the accepting edge. mtlo: lo<=rs_data at the accepting edge. Single cycle; state stays IDLE.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on accepted mult/multu; IDLE -> DIV on accepted div/divu.
  - At acceptance: latch operand magnitudes (abs value for signed ops, raw for unsigned), the result-sign flags, and counter=0.
  - MUL/DIV: one iteration per cycle. After DATA_W iterations (counter==DATA_W-1 at the edge) -> FIX.
  - FIX: apply sign correction and write hi/lo at the edge -> IDLE.
  - busy=1 in MUL, DIV and FIX.
  - Latency: acceptance edge k, hi/lo updated at edge k+DATA_W+1 (k+33), busy low from that cycle.
- Multiply: 64-bit product; hi=upper, lo=lower. Signed: product negated (two's complement, 64-bit) when operand signs differ.
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient negated when operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero (rt_data==0, both div and divu): lo=all ones, hi=rs_data unmodified, still after full latency.
  - Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0 (natural wrap, no trap).
- flush:
  - In any state: next edge state=IDLE, counter=0; hi/lo keep their pre-operation values.
  - flush and start in the same cycle: flush wins, nothing accepted.
- Non-MD instructions and start=0: no effect, stall=0.
- Mid-operation reset: immediate IDLE and all outputs cleared as above.

Test Plan:
- Reset released, mult rs=0xFFFFFFFE (-2), rt=3 -> busy high 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at edge k+33; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0, no extra cycles.
- mflo presented 5 cycles after a mult accept -> stall=1 every cycle until busy falls; then stall=0 and mf_data equals the new lo in that cycle.
- mthi rs=0x12345678 while IDLE -> hi=0x12345678 next edge, busy stays 0; same request while busy -> stall=1, hi unchanged.
- flush at cycle 10 of a div with hi/lo=0xAAAA/0x5555 -> IDLE next edge, busy=0, hi/lo unchanged; reset pulse mid-mult -> hi=lo=0, busy=0 immediately.
